tqvp_hx2003_symbol_streamer: RTL

//   Upstream feeder for the pulse transmitter. Buffers 32-bit symbol words written by the

---
 rtl/tqvp_hx2003_symbol_streamer.sv | 97 +++++++++
 1 files changed

// File: rtl/tqvp_hx2003_symbol_streamer.sv
// Symbol FIFO feeding the pulse transmitter: buffers 32-bit words from the CPU and
// serves one 2-bit symbol per request through a word-wide output stage.
module tqvp_hx2003_symbol_streamer #(
  parameter int DEPTH     = 4,
  parameter int LOW_WATER = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [31:0]   wr_data,
  output logic          wr_ready,
  input  logic          flush,
  input  logic          clr_flags,
  input  logic          sym_req,
  output logic [1:0]    sym_data,
  output logic          sym_valid,
  output logic [CW-1:0] fifo_count,
  output logic          low_water,
  output logic          overflow,
  output logic          underflow
);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   word;
  logic [3:0]    sym_idx;

  logic push, pop, consume, full, empty;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_valid && !full;
  assign consume = sym_req && sym_valid;
  // The stage refills either when idle or when its last symbol is consumed, so
  // back-to-back words stream without a bubble.
  assign pop     = !empty && (!sym_valid || (consume && sym_idx == 4'd15));

  assign wr_ready   = !full;
  assign low_water  = (count <= CW'(LOW_WATER));
  assign fifo_count = count;
  assign sym_data   = word[{sym_idx, 1'b0} +: 2];

  // Storage needs no reset: only entries counted in 'count' are ever read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      word      <= '0;
      sym_idx   <= '0;
      sym_valid <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      sym_idx   <= '0;
      sym_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        word      <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PW'(1);
        sym_idx   <= '0;
        sym_valid <= 1'b1;
      end else if (consume) begin
        if (sym_idx != 4'd15) sym_idx   <= sym_idx + 4'd1;
        else                  sym_valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle beats clr_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_valid && full && !flush) overflow <= 1'b1;
      else if (clr_flags)             overflow <= 1'b0;
      if (sym_req && !sym_valid)      underflow <= 1'b1;
      else if (clr_flags)             underflow <= 1'b0;
    end
  end

endmodule
